// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule types and constants.
package sha256_pkg;
  localparam int WORD_W = 32;
  localparam int N_IN   = 16;
  localparam int N_OUT  = 64;

  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {S_LOAD, S_EMIT} state_e;
endpackage

// File: rtl/sha256_sigma.sv
// SHA-256 small sigma word function: ROTR(A) ^ ROTR(B) ^ SHR(C), purely combinational.
module sha256_sigma
  import sha256_pkg::*;
#(
  parameter int ROT_A = 7,
  parameter int ROT_B = 18,
  parameter int SHR_C = 3
) (
  input  word_t x_i,
  output word_t y_o
);
  // Unsigned operand, so >> is a zero-filling logical shift.
  assign y_o = ((x_i >> ROT_A) | (x_i << (WORD_W - ROT_A)))
             ^ ((x_i >> ROT_B) | (x_i << (WORD_W - ROT_B)))
             ^ (x_i >> SHR_C);
endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16 words in, W[0..63] out over a valid/ready handshake.
// Optional build macro SHA256_SCHED_PASSTHRU_EN streams W[0..15] straight through during load.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        blk_valid,
  output logic        blk_ready,
  input  logic [31:0] blk_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        busy,
  output logic        done
);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  word_t       win_q [N_IN];
  word_t       win_d [N_IN];
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  word_t       s0, s1, w_new;
  logic        blk_acc, w_acc;

  sha256_sigma #(.ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR_C(S0_SHR))
    u_sigma0 (.x_i(win_q[1]), .y_o(s0));
  sha256_sigma #(.ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR_C(S1_SHR))
    u_sigma1 (.x_i(win_q[14]), .y_o(s1));

  // win[0] = W[t] so this is W[t+16]
  assign w_new = s1 + win_q[9] + s0 + win_q[0];

`ifdef SHA256_SCHED_PASSTHRU_EN
  localparam logic [5:0] EMIT_START = 6'd16;
  always_comb begin
    blk_ready = 1'b0;
    w_valid   = 1'b1;
    w_data    = w_new;
    w_index   = idx_q;
    if (state_q == S_LOAD) begin
      blk_ready = w_ready;
      w_valid   = blk_valid;
      w_data    = blk_word;
      w_index   = {2'b00, cnt_q};
    end
  end
`else
  localparam logic [5:0] EMIT_START = 6'd0;
  assign blk_ready = (state_q == S_LOAD);
  assign w_valid   = (state_q == S_EMIT);
  assign w_data    = win_q[0];
  assign w_index   = idx_q;
`endif

  assign blk_acc = blk_valid & blk_ready;
  assign w_acc   = w_valid & w_ready & (state_q == S_EMIT);
  assign busy    = busy_q;
  assign done    = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    for (int i = 0; i < N_IN; i++) win_d[i] = win_q[i];
    case (state_q)
      S_LOAD: begin
        if (blk_acc) begin
          for (int i = 0; i < N_IN-1; i++) win_d[i] = win_q[i+1];
          win_d[N_IN-1] = blk_word;
          busy_d = 1'b1;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'(N_IN-1)) begin
            state_d = S_EMIT;
            idx_d   = EMIT_START;
          end
        end
      end
      S_EMIT: begin
        if (w_acc) begin
          for (int i = 0; i < N_IN-1; i++) win_d[i] = win_q[i+1];
          win_d[N_IN-1] = w_new;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'(N_OUT-1)) begin
            state_d = S_LOAD;
            idx_d   = 6'd0;
            cnt_d   = 4'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_IN; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < N_IN; i++) win_q[i] <= win_d[i];
    end
  end
endmodule
